// File: rtl/showcase0_result_fifo.sv
// Result buffer for the Showcase0 datapath: a small FIFO holding each sum word
// together with its six comparison flags, plus running statistics on everything
// accepted at the input (sum accumulator, sticky carry flag, cmp_5 hit counter).
module showcase0_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        din_data,
  input  logic [5:0]                   din_flags,
  input  logic                         din_vld,
  output logic                         din_rd,
  output logic [DATA_WIDTH-1:0]        dout_data,
  output logic [5:0]                   dout_flags,
  output logic                         dout_vld,
  input  logic                         dout_rd,
  output logic [$clog2(DEPTH):0]       level,
  output logic [DATA_WIDTH-1:0]        acc,
  output logic                         acc_ovf,
  output logic [CNT_WIDTH-1:0]         eq_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 6;

  // Entry layout: flags in the top six bits, sum word below.
  logic [EW-1:0]         mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic                  acc_ovf_q, acc_ovf_d;
  logic [CNT_WIDTH-1:0]  eq_cnt_q, eq_cnt_d;

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH:0]   sum;

  // Handshakes decode registered occupancy only; din_rd is additionally masked by reset.
  assign dout_vld = (level_q != '0);
  assign din_rd   = (level_q != LW'(DEPTH)) & ~rst;
  assign wr_en    = din_vld & din_rd;
  assign rd_en    = dout_vld & dout_rd;

  assign {dout_flags, dout_data} = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign acc     = acc_q;
  assign acc_ovf = acc_ovf_q;
  assign eq_cnt  = eq_cnt_q;

  // Next-state for pointers, occupancy and statistics.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    eq_cnt_d  = eq_cnt_q;
    sum       = {1'b0, acc_q} + {1'b0, din_data};

    // DEPTH is a power of two, so pointer increments wrap naturally.
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_en, rd_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (wr_en) begin
      acc_d     = sum[DATA_WIDTH-1:0];
      acc_ovf_d = acc_ovf_q | sum[DATA_WIDTH];
      if (din_flags[5] && (eq_cnt_q != '1)) eq_cnt_d = eq_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Control and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      eq_cnt_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      eq_cnt_q  <= eq_cnt_d;
    end
  end

  // Entry storage; writes only on an accepted input item.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; dout is don't-care until level is nonzero.
    if (wr_en) mem_q[wr_ptr_q] <= {din_flags, din_data};
  end

endmodule

// File: tb/tb_showcase0_result_fifo.sv
// Self-checking bench for showcase0_result_fifo. A queue-based model tracks the
// buffered items and the statistics; the counter is built narrow so saturation
// is reached quickly.
module tb_showcase0_result_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din_data = '0;
  logic [5:0]    din_flags = '0;
  logic          din_vld = 1'b0;
  logic          din_rd;
  logic [DW-1:0] dout_data;
  logic [5:0]    dout_flags;
  logic          dout_vld;
  logic          dout_rd = 1'b0;
  logic [LW-1:0] level;
  logic [DW-1:0] acc;
  logic          acc_ovf;
  logic [CW-1:0] eq_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW+5:0] mq[$];
  logic [DW-1:0] m_acc = '0;
  logic          m_ovf = 1'b0;
  int            m_cnt = 0;
  logic          obs_din_rd;
  logic          exp_din_rd;

  showcase0_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .din_data(din_data), .din_flags(din_flags), .din_vld(din_vld), .din_rd(din_rd),
    .dout_data(dout_data), .dout_flags(dout_flags), .dout_vld(dout_vld), .dout_rd(dout_rd),
    .level(level), .acc(acc), .acc_ovf(acc_ovf), .eq_cnt(eq_cnt)
  );

  always #5 clk = ~clk;

  // One clock: apply inputs at the falling edge, record din_rd, clock, update model.
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                      input logic [5:0] f, input logic rd);
    logic        wr, rdd;
    logic [DW:0] s;
    rst = r; din_vld = v; din_data = d; din_flags = f; dout_rd = rd;
    #1;
    obs_din_rd = din_rd;
    exp_din_rd = !r && (mq.size() != DEPTH);
    @(posedge clk);
    if (r) begin
      mq.delete(); m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
    end else begin
      wr  = v && (mq.size() != DEPTH);
      rdd = rd && (mq.size() != 0);
      if (rdd) void'(mq.pop_front());
      if (wr) begin
        mq.push_back({f, d});
        s = {1'b0, m_acc} + {1'b0, d};
        m_acc = s[DW-1:0];
        m_ovf = m_ovf | s[DW];
        if (f[5] && m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 1, 32'h5, 6'h3f, 1);
    checks++; if (obs_din_rd !== 1'b0) begin errors++; $display("FAIL reset_din_rd got %0b exp 0", obs_din_rd); end
    step(1, 0, 0, 0, 0);
    rst = 1'b0; #1;
    checks++; if (dout_vld !== 1'b0) begin errors++; $display("FAIL reset_dout_vld got %0b exp 0", dout_vld); end
    checks++; if (din_rd !== 1'b1) begin errors++; $display("FAIL reset_din_rd_after got %0b exp 1", din_rd); end
    checks++; if (level !== '0 || acc !== '0 || acc_ovf !== 1'b0 || eq_cnt !== '0) begin
      errors++; $display("FAIL reset_state level %0d acc %h ovf %0b cnt %0d exp all zero", level, acc, acc_ovf, eq_cnt);
    end
  endtask

  task automatic test_single();
    step(0, 1, 32'h10, 6'b100000, 0);
    checks++; if (dout_vld !== 1'b1 || dout_data !== 32'h10 || dout_flags !== 6'h20) begin
      errors++; $display("FAIL single_dout vld %0b data %h flags %h exp 1 10 20", dout_vld, dout_data, dout_flags);
    end
    checks++; if (level !== 3'd1 || acc !== 32'h10 || eq_cnt !== 2'd1) begin
      errors++; $display("FAIL single_stats level %0d acc %h cnt %0d exp 1 10 1", level, acc, eq_cnt);
    end
    step(0, 0, 0, 0, 1);
    checks++; if (dout_vld !== 1'b0 || level !== 3'd0) begin
      errors++; $display("FAIL single_drain vld %0b level %0d exp 0 0", dout_vld, level);
    end
  endtask

  task automatic test_fill_and_drain();
    logic held;
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, DW'(i), 6'(i), 0);
      if (i == 5) begin
        checks++; if (obs_din_rd !== 1'b0) begin errors++; $display("FAIL full_din_rd got %0b exp 0", obs_din_rd); end
      end
    end
    checks++; if (level !== 3'd4 || din_rd !== 1'b0) begin
      errors++; $display("FAIL full_level level %0d din_rd %0b exp 4 0", level, din_rd);
    end
    held = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (dout_vld !== 1'b1 || dout_data !== DW'(k) || dout_flags !== 6'(k)) begin
        errors++; $display("FAIL drain_order[%0d] vld %0b data %h flags %h exp 1 %h %h", k, dout_vld, dout_data, dout_flags, k, k);
      end
      step(0, held, 32'd5, 6'd5, 1);
      if (held && obs_din_rd) held = 1'b0;
      if (k == 1) begin
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_rd_and_wr level %0d exp 3", level); end
      end
    end
    checks++; if (dout_vld !== 1'b0 || held !== 1'b0) begin
      errors++; $display("FAIL drain_empty vld %0b held %0b exp 0 0", dout_vld, held);
    end
  endtask

  task automatic test_back_to_back();
    step(0, 1, 32'h100, 6'h1, 0);
    step(0, 1, 32'h101, 6'h2, 0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(0, 1, 32'h102 + DW'(i), 6'(i), 1);
      checks++; if (level !== 3'd2 || dout_data !== 32'h101 + DW'(i) || dout_flags !== mq[0][DW+5:DW]) begin
        errors++; $display("FAIL b2b[%0d] level %0d data %h exp 2 %h", i, level, dout_data, 32'h101 + DW'(i));
      end
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'hFFFF_FFF0, 6'h0, 1);
    checks++; if (acc !== 32'hFFFF_FFF0 || acc_ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_first acc %h ovf %0b exp fffffff0 0", acc, acc_ovf);
    end
    step(0, 1, 32'h0000_0020, 6'h0, 1);
    checks++; if (acc !== 32'h10 || acc_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_carry acc %h ovf %0b exp 10 1", acc, acc_ovf);
    end
    step(0, 1, 32'h3, 6'h0, 1);
    step(0, 1, 32'h4, 6'h0, 1);
    checks++; if (acc !== 32'h17 || acc_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky acc %h ovf %0b exp 17 1", acc, acc_ovf);
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_eq_cnt_saturate();
    logic [CW-1:0] exp_seq [5];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd3; exp_seq[4] = 2'd3;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, DW'(i), 6'b100000, 1);
      checks++; if (eq_cnt !== exp_seq[i]) begin errors++; $display("FAIL eq_cnt_hit[%0d] got %0d exp %0d", i, eq_cnt, exp_seq[i]); end
      step(0, 1, DW'(i), 6'b011111, 1);
      checks++; if (eq_cnt !== exp_seq[i]) begin errors++; $display("FAIL eq_cnt_miss[%0d] got %0d exp %0d", i, eq_cnt, exp_seq[i]); end
    end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(0, 1, 32'h8000_0000, 6'h20, 0);
    checks++; if (level !== 3'd3 || acc_ovf !== 1'b1) begin
      errors++; $display("FAIL midrst_setup level %0d ovf %0b exp 3 1", level, acc_ovf);
    end
    step(1, 1, 32'h1, 6'h20, 1);
    checks++; if (obs_din_rd !== 1'b0) begin errors++; $display("FAIL midrst_din_rd got %0b exp 0", obs_din_rd); end
    checks++; if (level !== '0 || dout_vld !== 1'b0 || acc !== '0 || eq_cnt !== '0 || acc_ovf !== 1'b0) begin
      errors++; $display("FAIL midrst_state level %0d vld %0b acc %h cnt %0d ovf %0b exp all zero", level, dout_vld, acc, eq_cnt, acc_ovf);
    end
  endtask

  task automatic test_random();
    logic r, v, rd;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      v  = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 45);
      step(r, v, DW'($urandom), 6'($urandom), rd);
      checks++; if (obs_din_rd !== exp_din_rd) begin
        errors++; $display("FAIL rnd_din_rd[%0d] got %0b exp %0b", i, obs_din_rd, exp_din_rd);
      end
      checks++; if (level !== LW'(mq.size()) || dout_vld !== (mq.size() != 0)) begin
        errors++; $display("FAIL rnd_level[%0d] got %0d vld %0b exp %0d", i, level, dout_vld, mq.size());
      end
      if (mq.size() != 0) begin
        checks++; if ({dout_flags, dout_data} !== mq[0]) begin
          errors++; $display("FAIL rnd_head[%0d] got %h exp %h", i, {dout_flags, dout_data}, mq[0]);
        end
      end
      checks++; if (acc !== m_acc || acc_ovf !== m_ovf || eq_cnt !== CW'(m_cnt)) begin
        errors++; $display("FAIL rnd_stats[%0d] acc %h ovf %0b cnt %0d exp %h %0b %0d", i, acc, acc_ovf, eq_cnt, m_acc, m_ovf, m_cnt);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill_and_drain();
    test_back_to_back();
    test_overflow();
    test_eq_cnt_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
